// File: rtl/fillq_mc.sv
// fillq_mc: multi-entry L1 fill queue tracking outstanding line misses, issuing tagged memory
// reads, accepting out-of-order responses and replaying lines into mempipe. Macro FILLQ_MC_MERGE_EN.
module fillq_mc #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 26,
  parameter int CL_W        = 512,
  parameter int ID_W        = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_merge,
  output logic              alloc_full,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [ID_W-1:0]   mem_req_id,
  input  logic              mem_rsp_valid,
  input  logic [ID_W-1:0]   mem_rsp_id,
  input  logic [CL_W-1:0]   mem_rsp_data,
  output logic              pipe_req,
  input  logic              pipe_gnt,
  output logic [ADDR_W-1:0] pipe_req_addr,
  output logic [CL_W-1:0]   pipe_req_data,
  output logic [ID_W-1:0]   pipe_req_id,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } ent_st_e;

  ent_st_e           state_q [NUM_ENTRIES];
  ent_st_e           state_d [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_q  [NUM_ENTRIES];
  logic [CL_W-1:0]   data_q  [NUM_ENTRIES];

  logic [ID_W-1:0] mreq_ptr_q, mreq_ptr_d;
  logic [ID_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [ID_W-1:0] mreq_sel_q, mreq_sel_d;
  logic            mreq_lock_q, mreq_lock_d;
  logic            busy_q, busy_d;

  logic [NUM_ENTRIES-1:0] idle_vec, req_vec, fill_vec, hit_vec;
  logic [NUM_ENTRIES-1:0] alloc_en, hs_en, rsp_en, done_en;
  logic [ID_W-1:0]        mreq_sel, fill_sel, free_sel;
  logic                   mem_req_fire, fill_fire, alloc_take;

  // First set bit of vec at or after ptr, wrapping modulo NUM_ENTRIES.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_ENTRIES-1:0] vec,
                                               input logic [ID_W-1:0]        ptr);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_ENTRIES;
      if (vec[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return ID_W'((int'(p) + 1) % NUM_ENTRIES);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idle_vec[i] = (state_q[i] == ST_IDLE);
      req_vec[i]  = (state_q[i] == ST_REQ);
      fill_vec[i] = (state_q[i] == ST_FILL);
      hit_vec[i]  = (state_q[i] != ST_IDLE) && (addr_q[i] == lookup_addr);
    end
  end

  always_comb begin
    free_sel = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (idle_vec[i]) free_sel = ID_W'(i);
    end
  end

  // A stalled request keeps its entry until memory accepts it.
  assign mreq_sel      = mreq_lock_q ? mreq_sel_q : rr_pick(req_vec, mreq_ptr_q);
  assign mem_req_valid = |req_vec;
  assign mem_req_fire  = mem_req_valid & mem_req_ready;

  assign fill_sel  = rr_pick(fill_vec, fill_ptr_q);
  assign pipe_req  = |fill_vec;
  assign fill_fire = pipe_req & pipe_gnt;

`ifdef FILLQ_MC_MERGE_EN
  logic [NUM_ENTRIES-1:0] merge_vec;

  // An entry being released this cycle no longer represents an outstanding miss.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      merge_vec[i] = (state_q[i] != ST_IDLE) && (addr_q[i] == alloc_addr) && !done_en[i];
    end
  end

  assign alloc_merge = alloc_valid & (|merge_vec);
`else
  assign alloc_merge = 1'b0;
`endif

  assign alloc_full = alloc_valid & ~(|idle_vec) & ~alloc_merge;
  assign alloc_take = alloc_valid & ~alloc_merge & (|idle_vec);

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      alloc_en[i] = alloc_take && (free_sel == ID_W'(i));
      hs_en[i]    = mem_req_fire && (mreq_sel == ID_W'(i));
      rsp_en[i]   = mem_rsp_valid && (mem_rsp_id == ID_W'(i)) && (state_q[i] == ST_WAIT);
      done_en[i]  = fill_fire && (fill_sel == ID_W'(i));
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (alloc_en[i]) state_d[i] = ST_REQ;
        ST_REQ:  if (hs_en[i])    state_d[i] = ST_WAIT;
        ST_WAIT: if (rsp_en[i])   state_d[i] = ST_FILL;
        ST_FILL: if (done_en[i])  state_d[i] = ST_IDLE;
        default:                  state_d[i] = ST_IDLE;
      endcase
      if (state_d[i] != ST_IDLE) busy_d = 1'b1;
    end
    mreq_ptr_d  = mem_req_fire ? ptr_inc(mreq_sel) : mreq_ptr_q;
    fill_ptr_d  = fill_fire ? ptr_inc(fill_sel) : fill_ptr_q;
    mreq_lock_d = mem_req_valid & ~mem_req_ready;
    mreq_sel_d  = mreq_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= ST_IDLE;
      mreq_ptr_q  <= '0;
      fill_ptr_q  <= '0;
      mreq_sel_q  <= '0;
      mreq_lock_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
      mreq_ptr_q  <= mreq_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      mreq_sel_q  <= mreq_sel_d;
      mreq_lock_q <= mreq_lock_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage is only observed through a non-IDLE entry, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc_en[i]) addr_q[i] <= alloc_addr;
      if (rsp_en[i])   data_q[i] <= mem_rsp_data;
    end
  end

  assign mem_req_addr  = mem_req_valid ? addr_q[mreq_sel] : '0;
  assign mem_req_id    = mem_req_valid ? mreq_sel : '0;
  assign pipe_req_addr = pipe_req ? addr_q[fill_sel] : '0;
  assign pipe_req_data = pipe_req ? data_q[fill_sel] : '0;
  assign pipe_req_id   = pipe_req ? fill_sel : '0;
  assign lookup_hit    = |hit_vec;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fillq_mc.sv
// tb_fillq_mc: directed stimulus for fillq_mc with a per-cycle behavioural model plus literal pins.
module tb_fillq_mc;
  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int IW = 2;
`ifdef FILLQ_MC_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic          clk, reset;
  logic          alloc_valid, alloc_merge, alloc_full;
  logic [AW-1:0] alloc_addr;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [IW-1:0] mem_req_id;
  logic          mem_rsp_valid;
  logic [IW-1:0] mem_rsp_id;
  logic [DW-1:0] mem_rsp_data;
  logic          pipe_req, pipe_gnt;
  logic [AW-1:0] pipe_req_addr;
  logic [DW-1:0] pipe_req_data;
  logic [IW-1:0] pipe_req_id;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit, busy;

  fillq_mc #(.NUM_ENTRIES(N), .ADDR_W(AW), .CL_W(DW)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .alloc_merge(alloc_merge), .alloc_full(alloc_full),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
    .pipe_req(pipe_req), .pipe_gnt(pipe_gnt), .pipe_req_addr(pipe_req_addr),
    .pipe_req_data(pipe_req_data), .pipe_req_id(pipe_req_id),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int ord[4] = '{3, 1, 0, 2};

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0h, required %0h", nm, cyc, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  task automatic chkA(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  task automatic chkI(input string nm, input logic [IW-1:0] act, input int exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  function automatic logic [DW-1:0] dpat(input int k);
    return {16{32'h5a5a0000 ^ 32'(k)}};
  endfunction

  // Behavioural model: each entry is a miss that is used, then sent, then back with data.
  bit            m_used[N], m_sent[N], m_back[N];
  logic [AW-1:0] m_addr[N];
  logic [DW-1:0] m_data[N];
  int            m_mptr, m_fptr, m_lsel, jj;
  bit            m_lock, m_busy;
  bit            e_mv, e_fv, e_hit, e_merge, e_full, e_ffire, e_freef;
  int            e_ms, e_fs, e_free;

  always @(negedge clk) begin
    #4;
    cyc++;
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        m_used[j] = 1'b0; m_sent[j] = 1'b0; m_back[j] = 1'b0;
      end
      m_mptr = 0; m_fptr = 0; m_lsel = 0; m_lock = 1'b0; m_busy = 1'b0;
    end
    e_mv = m_lock;
    e_ms = m_lsel;
    if (!m_lock) begin
      for (int k = 0; k < N; k++) begin
        jj = (m_mptr + k) % N;
        if (!e_mv && m_used[jj] && !m_sent[jj]) begin e_mv = 1'b1; e_ms = jj; end
      end
    end
    e_fv = 1'b0; e_fs = 0;
    for (int k = 0; k < N; k++) begin
      jj = (m_fptr + k) % N;
      if (!e_fv && m_back[jj]) begin e_fv = 1'b1; e_fs = jj; end
    end
    e_ffire = e_fv && pipe_gnt;
    e_hit = 1'b0; e_merge = 1'b0; e_freef = 1'b0; e_free = 0;
    for (int j = 0; j < N; j++) begin
      if (m_used[j] && m_addr[j] == lookup_addr) e_hit = 1'b1;
      if (MERGE && alloc_valid && m_used[j] && m_addr[j] == alloc_addr && !(e_ffire && j == e_fs))
        e_merge = 1'b1;
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (!m_used[j]) begin e_freef = 1'b1; e_free = j; end
    end
    e_full = alloc_valid && !e_freef && !e_merge;

    chk1("mreq_valid", mem_req_valid, e_mv);
    chkA("mreq_addr", mem_req_addr, e_mv ? m_addr[e_ms] : '0);
    chkI("mreq_id", mem_req_id, e_mv ? e_ms : 0);
    chk1("pipe_req", pipe_req, e_fv);
    chkA("pipe_addr", pipe_req_addr, e_fv ? m_addr[e_fs] : '0);
    chk("pipe_data", pipe_req_data, e_fv ? m_data[e_fs] : '0);
    chkI("pipe_id", pipe_req_id, e_fv ? e_fs : 0);
    chk1("lookup_hit", lookup_hit, e_hit);
    chk1("alloc_merge", alloc_merge, e_merge);
    chk1("alloc_full", alloc_full, e_full);
    chk1("busy", busy, m_busy);

    if (reset) begin
      if (e_ffire) begin
        m_used[e_fs] = 1'b0; m_sent[e_fs] = 1'b0; m_back[e_fs] = 1'b0;
        m_fptr = (e_fs + 1) % N;
      end
      if (mem_rsp_valid && m_sent[mem_rsp_id] && !m_back[mem_rsp_id]) begin
        m_back[mem_rsp_id] = 1'b1;
        m_data[mem_rsp_id] = mem_rsp_data;
      end
      if (e_mv && mem_req_ready) begin
        m_sent[e_ms] = 1'b1;
        m_mptr = (e_ms + 1) % N;
      end
      m_lock = e_mv && !mem_req_ready;
      m_lsel = e_ms;
      if (alloc_valid && !e_merge && e_freef) begin
        m_used[e_free] = 1'b1; m_sent[e_free] = 1'b0; m_back[e_free] = 1'b0;
        m_addr[e_free] = alloc_addr;
      end
      m_busy = 1'b0;
      for (int j = 0; j < N; j++) if (m_used[j]) m_busy = 1'b1;
    end
  end

  task automatic nxt();
    @(negedge clk);
    alloc_valid   = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic smp();
    #4;
  endtask

  task automatic alc(input logic [AW-1:0] a);
    alloc_valid = 1'b1;
    alloc_addr  = a;
  endtask

  task automatic rsp(input int id, input logic [DW-1:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = IW'(id);
    mem_rsp_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; alloc_valid = 1'b0; alloc_addr = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_id = '0; mem_rsp_data = '0; pipe_gnt = 1'b1; lookup_addr = '0;
    @(negedge clk); @(negedge clk); smp();
    chk1("L_rst_mreq", mem_req_valid, 1'b0);
    chk1("L_rst_pipe", pipe_req, 1'b0);
    chk1("L_rst_busy", busy, 1'b0);
    chkA("L_rst_addr", mem_req_addr, 26'h0);
    @(negedge clk); reset = 1'b1;

    // single miss end to end
    nxt(); alc(26'h100);
    nxt(); smp();
    chk1("L_t1_mreq", mem_req_valid, 1'b1);
    chkA("L_t1_addr", mem_req_addr, 26'h100);
    chkI("L_t1_id", mem_req_id, 0);
    chk1("L_t1_busy", busy, 1'b1);
    repeat (7) nxt();
    nxt(); rsp(0, dpat(1));
    nxt(); smp();
    chk1("L_t1_pipe", pipe_req, 1'b1);
    chk("L_t1_data", pipe_req_data, dpat(1));
    chkA("L_t1_paddr", pipe_req_addr, 26'h100);
    nxt(); smp();
    chk1("L_t1_idle", busy, 1'b0);

    // fill all entries, overflow, out-of-order returns
    for (int k = 0; k < 4; k++) begin nxt(); alc(26'h10 + 26'(k)); end
    nxt(); alc(26'h14); smp();
    chk1("L_t2_full", alloc_full, 1'b1);
    nxt();
    for (int k = 0; k < 5; k++) begin
      nxt();
      if (k < 4) rsp(ord[k], dpat(10 + ord[k]));
      smp();
      if (k > 0) begin
        chk1("L_t2_fillv", pipe_req, 1'b1);
        chkI("L_t2_order", pipe_req_id, ord[k-1]);
      end
    end

    // stalled memory request keeps its selection
    nxt(); mem_req_ready = 1'b0; alc(26'h20);
    nxt(); alc(26'h21); smp();
    chkI("L_t3_hold_id", mem_req_id, 0); chkA("L_t3_hold_addr", mem_req_addr, 26'h20);
    nxt(); alc(26'h22); smp();
    chkI("L_t3_hold_id", mem_req_id, 0); chkA("L_t3_hold_addr", mem_req_addr, 26'h20);
    repeat (3) begin
      nxt(); smp();
      chkI("L_t3_hold_id", mem_req_id, 0); chkA("L_t3_hold_addr", mem_req_addr, 26'h20);
    end
    for (int k = 0; k < 3; k++) begin
      nxt(); mem_req_ready = 1'b1; smp();
      chk1("L_t3_rr_v", mem_req_valid, 1'b1);
      chkI("L_t3_rr_id", mem_req_id, k);
    end
    nxt(); pipe_gnt = 1'b0; rsp(2, dpat(22)); smp();
    chk1("L_t3_done", mem_req_valid, 1'b0);
    nxt(); rsp(0, dpat(20));
    nxt(); rsp(1, dpat(21));
    for (int k = 0; k < 3; k++) begin
      nxt(); pipe_gnt = 1'b1; smp();
      chkI("L_t3_fill_rr", pipe_req_id, k);
    end

    // duplicate address: merge or second entry
    nxt(); alc(26'h200);
    nxt(); nxt();
    nxt(); alc(26'h200); smp();
    chk1("L_t4_merge", alloc_merge, MERGE);
    nxt(); rsp(0, dpat(30)); smp();
    chk1("L_t4_req2", mem_req_valid, !MERGE);
    chkI("L_t4_id2", mem_req_id, MERGE ? 0 : 1);
    nxt(); smp();
    chk1("L_t4_fill", pipe_req, 1'b1);
    nxt(); rsp(1, dpat(31));
    repeat (2) nxt();

    // lookup lifetime and stale response
    nxt(); lookup_addr = 26'h300; alc(26'h300); smp();
    chk1("L_t5_lk_idle", lookup_hit, 1'b0);
    nxt(); nxt(); smp();
    chk1("L_t5_lk_wait", lookup_hit, 1'b1);
    nxt(); rsp(0, dpat(40));
    nxt(); smp();
    chk1("L_t5_lk_fill", lookup_hit, 1'b1);
    nxt(); smp();
    chk1("L_t5_lk_gone", lookup_hit, 1'b0);
    nxt(); rsp(2, dpat(41));
    nxt(); smp();
    chk1("L_t5_stale", pipe_req, 1'b0);

    // alloc to the address being released this cycle
    nxt(); alc(26'h500);
    nxt(); nxt();
    nxt(); rsp(0, dpat(50));
    nxt(); alc(26'h500); smp();
    chk1("L_t5b_nomerge", alloc_merge, 1'b0);
    chk1("L_t5b_nofull", alloc_full, 1'b0);
    chk1("L_t5b_fill", pipe_req, 1'b1);
    nxt(); smp();
    chkI("L_t5b_id", mem_req_id, 1);
    chkA("L_t5b_addr", mem_req_addr, 26'h500);
    nxt();
    nxt(); rsp(1, dpat(51));
    repeat (2) nxt();

    // reset mid-operation, stale response afterwards
    nxt(); alc(26'h400);
    nxt(); alc(26'h401);
    nxt();
    nxt(); smp();
    chk1("L_t6_busy", busy, 1'b1);
    nxt(); reset = 1'b0; lookup_addr = 26'h400; smp();
    chk1("L_t6_mreq", mem_req_valid, 1'b0);
    chk1("L_t6_pipe", pipe_req, 1'b0);
    chk1("L_t6_busy0", busy, 1'b0);
    chk1("L_t6_lk", lookup_hit, 1'b0);
    nxt(); reset = 1'b1;
    nxt(); rsp(0, dpat(60));
    nxt(); smp();
    chk1("L_t6_stale", pipe_req, 1'b0);
    chk1("L_t6_idle", busy, 1'b0);
    repeat (2) nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
